// File: rtl/grf_wb_arbiter_pkg.sv
// Shared constants and types for the GRF writeback arbiter.
//   REG_AW / DATA_W      : register address and data widths
//   WB_PORT_PIPE / _MD   : requester indices (main pipeline W stage, mul/div unit)
//   WAIT_W               : width of the starvation counter
//   wb_grant_e           : grant decision of the arbiter
//   wb_req_t             : one writeback request (addr, data, pc)
package grf_wb_arbiter_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WAIT_W = 4;

  localparam logic [0:0] WB_PORT_PIPE = 1'b0;
  localparam logic [0:0] WB_PORT_MD   = 1'b1;

  typedef enum logic [1:0] {
    GntNone = 2'd0,
    GntPipe = 2'd1,
    GntMd   = 2'd2
  } wb_grant_e;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
  } wb_req_t;

  // $0 is hard-wired; a write to it is accepted but never enabled.
  function automatic logic wb_writes_reg(input logic [REG_AW-1:0] addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/grf_wb_arbiter_if.sv
// Bus bundle between the two writeback requesters, the arbiter and the GRF write port.
//   req0_* : main pipeline W stage request (valid/ready/addr/data/pc)
//   req1_* : mul/div unit request (valid/ready/addr/data/pc)
//   grf_*  : registered GRF write port (we/a3/wd/pc)
//   wait_cnt, conflict_cnt : status counters
// Modports: slave = arbiter side, master = requester/GRF side.
interface grf_wb_arbiter_if #(
  parameter int unsigned CNT_W = 16
);
  import grf_wb_arbiter_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [REG_AW-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic [DATA_W-1:0] req0_pc;

  logic              req1_valid;
  logic              req1_ready;
  logic [REG_AW-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic [DATA_W-1:0] req1_pc;

  logic              grf_we;
  logic [REG_AW-1:0] grf_a3;
  logic [DATA_W-1:0] grf_wd;
  logic [DATA_W-1:0] grf_pc;

  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  conflict_cnt;

  modport slave (
    input  req0_valid, req0_addr, req0_data, req0_pc,
    input  req1_valid, req1_addr, req1_data, req1_pc,
    output req0_ready, req1_ready,
    output grf_we, grf_a3, grf_wd, grf_pc,
    output wait_cnt, conflict_cnt
  );

  modport master (
    output req0_valid, req0_addr, req0_data, req0_pc,
    output req1_valid, req1_addr, req1_data, req1_pc,
    input  req0_ready, req1_ready,
    input  grf_we, grf_a3, grf_wd, grf_pc,
    input  wait_cnt, conflict_cnt
  );

endinterface

// File: rtl/grf_wb_arbiter_wb_starve_ctr.sv
// Starvation counter for one low-priority requester.
// Counts consecutive refused cycles (valid && !ready), saturating at MAX_WAIT, and
// raises o_force once the count reaches MAX_WAIT so the arbiter hands that port the grant.
//   clk, reset : clock, synchronous active-high reset
//   i_valid    : requester has a pending request
//   i_ready    : requester was granted this cycle
//   o_cnt      : current refused-cycle count
//   o_force    : requester must win this cycle
module wb_starve_ctr
  import grf_wb_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic              i_ready,
  output logic [WAIT_W-1:0] o_cnt,
  output logic              o_force
);

  localparam logic [WAIT_W-1:0] MaxWait = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] r_cnt;
  logic [WAIT_W-1:0] w_cnt_next;

  // Any accept or a dropped request restarts the count.
  always_comb begin
    w_cnt_next = '0;
    if (i_valid && !i_ready) begin
      w_cnt_next = (r_cnt == MaxWait) ? r_cnt : r_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign o_cnt   = r_cnt;
  assign o_force = i_valid && (r_cnt == MaxWait);

endmodule

// File: rtl/grf_wb_arbiter.sv
// Two-port writeback arbiter in front of the single GRF write port.
// Port 0 (pipeline W stage) normally wins; port 1 (mul/div) wins when alone or once it
// has been refused MAX_WAIT cycles in a row. The winning write is registered and shows
// up on the GRF port one cycle after the handshake.
//   clk, reset : clock, synchronous active-high reset
//   bus        : grf_wb_arbiter_if slave modport (requests, readies, GRF port, counters)
module grf_wb_arbiter
  import grf_wb_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 16
) (
  input logic             clk,
  input logic             reset,
  grf_wb_arbiter_if.slave bus
);

  wb_grant_e         w_grant;
  logic              w_force_md;
  logic              w_both;
  logic [0:0]        w_sel;
  wb_req_t           w_req [2];
  wb_req_t           w_win;

  logic              r_we;
  logic [REG_AW-1:0] r_a3;
  logic [DATA_W-1:0] r_wd;
  logic [DATA_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_conflict_cnt;

  assign w_req[WB_PORT_PIPE] = '{addr: bus.req0_addr, data: bus.req0_data, pc: bus.req0_pc};
  assign w_req[WB_PORT_MD]   = '{addr: bus.req1_addr, data: bus.req1_data, pc: bus.req1_pc};

  assign w_both = bus.req0_valid && bus.req1_valid;

  // No handshake may complete while reset is asserted.
  always_comb begin
    w_grant = GntNone;
    if (!reset) begin
      if (w_both) begin
        w_grant = w_force_md ? GntMd : GntPipe;
      end else if (bus.req0_valid) begin
        w_grant = GntPipe;
      end else if (bus.req1_valid) begin
        w_grant = GntMd;
      end
    end
  end

  assign bus.req0_ready = (w_grant == GntPipe);
  assign bus.req1_ready = (w_grant == GntMd);

  assign w_sel = (w_grant == GntMd) ? WB_PORT_MD : WB_PORT_PIPE;
  assign w_win = w_req[w_sel];

  wb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk     (clk),
    .reset   (reset),
    .i_valid (bus.req1_valid),
    .i_ready (bus.req1_ready),
    .o_cnt   (bus.wait_cnt),
    .o_force (w_force_md)
  );

  // Address/data/pc follow every accept; we only for real destinations.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we <= 1'b0;
      r_a3 <= '0;
      r_wd <= '0;
      r_pc <= '0;
    end else if (w_grant != GntNone) begin
      r_we <= wb_writes_reg(w_win.addr);
      r_a3 <= w_win.addr;
      r_wd <= w_win.data;
      r_pc <= w_win.pc;
    end else begin
      r_we <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_conflict_cnt <= '0;
    end else if (w_both && (r_conflict_cnt != '1)) begin
      r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
    end
  end

  assign bus.grf_we       = r_we;
  assign bus.grf_a3       = r_a3;
  assign bus.grf_wd       = r_wd;
  assign bus.grf_pc       = r_pc;
  assign bus.conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Self-checking bench for grf_wb_arbiter: a vector table for the main sequences, a
// hand-written saturation run, and a scoreboard queue for the registered GRF writes.
module tb_grf_wb_arbiter;
  import grf_wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grf_wb_arbiter_if #(.CNT_W(16)) bus ();
  grf_wb_arbiter_if #(.CNT_W(4))  bus4 ();

  // Narrow-counter instance sees identical stimulus.
  assign bus4.req0_valid = bus.req0_valid;
  assign bus4.req0_addr  = bus.req0_addr;
  assign bus4.req0_data  = bus.req0_data;
  assign bus4.req0_pc    = bus.req0_pc;
  assign bus4.req1_valid = bus.req1_valid;
  assign bus4.req1_addr  = bus.req1_addr;
  assign bus4.req1_data  = bus.req1_data;
  assign bus4.req1_pc    = bus.req1_pc;

  grf_wb_arbiter #(.MAX_WAIT(4), .CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  grf_wb_arbiter #(.MAX_WAIT(4), .CNT_W(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  typedef struct {
    logic        rst;
    logic        r0v;
    logic [4:0]  r0a;
    logic [31:0] r0d;
    logic [31:0] r0p;
    logic        r1v;
    logic [4:0]  r1a;
    logic [31:0] r1d;
    logic [31:0] r1p;
    logic        e_rdy0;
    logic        e_rdy1;
    logic [3:0]  e_wait;
    logic [15:0] e_conf;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } wr_t;

  vec_t        vecs[$];
  wr_t         sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [4:0]  m_a3 = '0;
  logic [31:0] m_wd = '0;
  logic [31:0] m_pc = '0;

  function automatic vec_t mk(input logic rst,
                              input logic r0v, input logic [4:0] r0a,
                              input logic [31:0] r0d, input logic [31:0] r0p,
                              input logic r1v, input logic [4:0] r1a,
                              input logic [31:0] r1d, input logic [31:0] r1p,
                              input logic e0, input logic e1,
                              input logic [3:0] ew, input logic [15:0] ec);
    vec_t v;
    v.rst = rst;  v.r0v = r0v; v.r0a = r0a; v.r0d = r0d; v.r0p = r0p;
    v.r1v = r1v;  v.r1a = r1a; v.r1d = r1d; v.r1p = r1p;
    v.e_rdy0 = e0; v.e_rdy1 = e1; v.e_wait = ew; v.e_conf = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one cycle, checks readies mid-cycle, queues the expected GRF write, then
  // checks the registered outputs and counters just after the edge.
  task automatic step(input vec_t v, input string tag);
    wr_t e;
    wr_t got;
    reset          = v.rst;
    bus.req0_valid = v.r0v; bus.req0_addr = v.r0a; bus.req0_data = v.r0d; bus.req0_pc = v.r0p;
    bus.req1_valid = v.r1v; bus.req1_addr = v.r1a; bus.req1_data = v.r1d; bus.req1_pc = v.r1p;
    @(negedge clk);
    chk({tag, " req0_ready"}, 32'(bus.req0_ready), 32'(v.e_rdy0));
    chk({tag, " req1_ready"}, 32'(bus.req1_ready), 32'(v.e_rdy1));
    if (v.rst) begin
      m_a3 = '0; m_wd = '0; m_pc = '0;
      e.we = 1'b0;
    end else if (v.e_rdy0 || v.e_rdy1) begin
      m_a3 = v.e_rdy1 ? v.r1a : v.r0a;
      m_wd = v.e_rdy1 ? v.r1d : v.r0d;
      m_pc = v.e_rdy1 ? v.r1p : v.r0p;
      e.we = (m_a3 != 5'd0);
    end else begin
      e.we = 1'b0;
    end
    e.a3 = m_a3; e.wd = m_wd; e.pc = m_pc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk({tag, " grf_we"}, 32'(bus.grf_we), 32'(got.we));
      chk({tag, " grf_a3"}, 32'(bus.grf_a3), 32'(got.a3));
      chk({tag, " grf_wd"}, bus.grf_wd, got.wd);
      chk({tag, " grf_pc"}, bus.grf_pc, got.pc);
    end
    chk({tag, " wait_cnt"}, 32'(bus.wait_cnt), 32'(v.e_wait));
    chk({tag, " conflict_cnt"}, 32'(bus.conflict_cnt), 32'(v.e_conf));
  endtask

  initial begin
    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0; bus.req0_pc = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0; bus.req1_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset grf_we", 32'(bus.grf_we), 32'd0);
    chk("reset grf_a3", 32'(bus.grf_a3), 32'd0);
    chk("reset grf_wd", bus.grf_wd, 32'd0);
    chk("reset grf_pc", bus.grf_pc, 32'd0);
    chk("reset wait_cnt", 32'(bus.wait_cnt), 32'd0);
    chk("reset conflict_cnt", 32'(bus.conflict_cnt), 32'd0);

    //                 rst r0v r0a    r0d         r0p          r1v r1a    r1d          r1p       rd0 rd1 wait conf
    // readies held low under reset even with both valid
    vecs.push_back(mk(1, 1, 5'd9, 32'h900,  32'h4000, 1, 5'd8, 32'hBEEF, 32'h5000, 0, 0, 4'd0, 16'd0));
    // req0 alone
    vecs.push_back(mk(0, 1, 5'd5, 32'h1234, 32'h3000, 0, 5'd0, 32'h0,    32'h0,    1, 0, 4'd0, 16'd0));
    vecs.push_back(mk(0, 0, 5'd0, 32'h0,    32'h0,    0, 5'd0, 32'h0,    32'h0,    0, 0, 4'd0, 16'd0));
    // sustained conflict: four wins for req0, then req1 is forced through
    vecs.push_back(mk(0, 1, 5'd9, 32'h900,  32'h4000, 1, 5'd8, 32'hBEEF, 32'h5000, 1, 0, 4'd1, 16'd1));
    vecs.push_back(mk(0, 1, 5'd9, 32'h901,  32'h4004, 1, 5'd8, 32'hBEEF, 32'h5000, 1, 0, 4'd2, 16'd2));
    vecs.push_back(mk(0, 1, 5'd9, 32'h902,  32'h4008, 1, 5'd8, 32'hBEEF, 32'h5000, 1, 0, 4'd3, 16'd3));
    vecs.push_back(mk(0, 1, 5'd9, 32'h903,  32'h400C, 1, 5'd8, 32'hBEEF, 32'h5000, 1, 0, 4'd4, 16'd4));
    vecs.push_back(mk(0, 1, 5'd9, 32'h904,  32'h4010, 1, 5'd8, 32'hBEEF, 32'h5000, 0, 1, 4'd0, 16'd5));
    // req1 to $0: accepted, no write enable
    vecs.push_back(mk(0, 0, 5'd0, 32'h0,    32'h0,    1, 5'd0, 32'hFFFF, 32'h6000, 0, 1, 4'd0, 16'd5));
    // back-to-back req0 writes
    vecs.push_back(mk(0, 1, 5'd1, 32'h11,   32'h100,  0, 5'd0, 32'h0,    32'h0,    1, 0, 4'd0, 16'd5));
    vecs.push_back(mk(0, 1, 5'd2, 32'h22,   32'h104,  0, 5'd0, 32'h0,    32'h0,    1, 0, 4'd0, 16'd5));
    vecs.push_back(mk(0, 1, 5'd3, 32'h33,   32'h108,  0, 5'd0, 32'h0,    32'h0,    1, 0, 4'd0, 16'd5));
    // wait_cnt clears when req1 withdraws
    vecs.push_back(mk(0, 1, 5'd4, 32'h44,   32'h10C,  1, 5'd7, 32'h77,   32'h700,  1, 0, 4'd1, 16'd6));
    vecs.push_back(mk(0, 1, 5'd5, 32'h55,   32'h110,  0, 5'd0, 32'h0,    32'h0,    1, 0, 4'd0, 16'd6));
    vecs.push_back(mk(0, 0, 5'd0, 32'h0,    32'h0,    1, 5'd7, 32'h77,   32'h700,  0, 1, 4'd0, 16'd6));
    // accept then reset: the registered write is dropped
    vecs.push_back(mk(0, 1, 5'd6, 32'h66,   32'h600,  0, 5'd0, 32'h0,    32'h0,    1, 0, 4'd0, 16'd6));
    vecs.push_back(mk(1, 1, 5'd6, 32'h67,   32'h604,  1, 5'd7, 32'h78,   32'h704,  0, 0, 4'd0, 16'd0));
    vecs.push_back(mk(0, 0, 5'd0, 32'h0,    32'h0,    0, 5'd0, 32'h0,    32'h0,    0, 0, 4'd0, 16'd0));

    foreach (vecs[i]) begin
      step(vecs[i], $sformatf("v%0d", i));
      chk($sformatf("v%0d conflict_cnt4", i), 32'(bus4.conflict_cnt), 32'(vecs[i].e_conf[3:0]));
    end

    // 20 cycles of conflict: req1 forced every fifth cycle, narrow counter sticks at 15
    for (int i = 0; i < 20; i++) begin
      logic        g1;
      logic [3:0]  ew;
      logic [15:0] ec;
      int          sat;
      g1  = ((i % 5) == 4);
      ew  = g1 ? 4'd0 : 4'((i % 5) + 1);
      ec  = 16'(i + 1);
      sat = (i + 1 > 15) ? 15 : i + 1;
      step(mk(0, 1, 5'(i % 31 + 1), 32'hA000 + 32'(i), 32'h8000 + 32'(4 * i),
              1, 5'd20, 32'hD000 + 32'(i), 32'h9000, !g1, g1, ew, ec),
           $sformatf("sat%0d", i));
      chk($sformatf("sat%0d conflict_cnt4", i), 32'(bus4.conflict_cnt), 32'(sat));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
